// File: rtl/array_update_pkg.sv
// Shared types and geometry for the array_update_pipe block.
// Element i of a flattened array lives at bits [i*ELEM_W +: ELEM_W].
package array_update_pkg;

  localparam int ELEM_W    = 32;
  localparam int NUM_ELEMS = 4;
  localparam int SEL_W     = 2;
  localparam int IDX_W     = SEL_W + 1;
  localparam int FLAT_W    = NUM_ELEMS * ELEM_W;

  typedef logic [ELEM_W-1:0]    elem_t;
  typedef elem_t [NUM_ELEMS-1:0] arr_t;
  typedef logic [SEL_W-1:0]     sel_t;
  typedef logic [IDX_W-1:0]     idx_t;

  function automatic arr_t unflatten(input logic [FLAT_W-1:0] flat);
    return arr_t'(flat);
  endfunction

  function automatic logic [FLAT_W-1:0] flatten(input arr_t a);
    return FLAT_W'(a);
  endfunction

endpackage

// File: rtl/array_update_comb.sv
// Pure combinational element replace: writes value into element sel+1.
// The oob port exists only when ARRAY_UPDATE_OOB_FLAG_EN is defined.
module array_update_comb
  import array_update_pkg::*;
(
  input  sel_t  sel,
  input  arr_t  arr,
  input  elem_t value,
  output arr_t  out
`ifdef ARRAY_UPDATE_OOB_FLAG_EN
  , output logic oob
`endif
);

  idx_t idx;

  // Widened add: sel=all-ones lands past the array rather than wrapping to 0.
  assign idx = {1'b0, sel} + IDX_W'(1);

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    out = arr;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      if (int'(idx) == i) out[i] = value;
    end
  end

`ifdef ARRAY_UPDATE_OOB_FLAG_EN
  assign oob = (int'(idx) >= NUM_ELEMS);
`endif

endmodule

// File: rtl/array_update_pipe.sv
// Two-stage valid/ready pipeline returning arr with element [sel+1] replaced by value.
// Optional oob output enabled by defining ARRAY_UPDATE_OOB_FLAG_EN.
module array_update_pipe
  import array_update_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  sel,
  input  logic [FLAT_W-1:0] arr,
  input  logic [ELEM_W-1:0] value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLAT_W-1:0] out
`ifdef ARRAY_UPDATE_OOB_FLAG_EN
  , output logic            oob
`endif
);

  logic  p0_valid, p1_valid;
  logic  ready_q;
  logic  p0_en, p1_en, accept;
  sel_t  p0_sel;
  arr_t  p0_arr;
  elem_t p0_value;
  arr_t  p1_arr;
  arr_t  upd_arr;

  assign p1_en    = !p1_valid || out_ready;
  assign p0_en    = !p0_valid || p1_en;
  // ready_q keeps in_ready low through reset and for the edge-free window right after it.
  assign in_ready = p0_en && ready_q;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    else        ready_q <= 1'b1;
  end

  // NOTE: data registers are reset too, so out reads 0 after reset rather than stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_valid <= 1'b0;
      p0_sel   <= '0;
      p0_arr   <= '0;
      p0_value <= '0;
    end else begin
      if (p0_en) p0_valid <= accept;
      if (accept) begin
        p0_sel   <= sel;
        p0_arr   <= unflatten(arr);
        p0_value <= value;
      end
    end
  end

`ifdef ARRAY_UPDATE_OOB_FLAG_EN
  logic upd_oob;
  logic p1_oob;

  array_update_comb u_comb (
    .sel   (p0_sel),
    .arr   (p0_arr),
    .value (p0_value),
    .out   (upd_arr),
    .oob   (upd_oob)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    p1_oob <= 1'b0;
    else if (p0_valid && p1_en)    p1_oob <= upd_oob;
  end

  assign oob = p1_oob;
`else
  array_update_comb u_comb (
    .sel   (p0_sel),
    .arr   (p0_arr),
    .value (p0_value),
    .out   (upd_arr)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_arr   <= '0;
    end else begin
      if (p1_en) p1_valid <= p0_valid;
      if (p0_valid && p1_en) p1_arr <= upd_arr;
    end
  end

  assign out_valid = p1_valid;
  assign out       = flatten(p1_arr);

endmodule

// File: tb/tb_array_update_pipe.sv
// Self-checking bench for array_update_pipe: directed steps plus a queue-based reference model.
// Checks oob only when ARRAY_UPDATE_OOB_FLAG_EN is defined.
module tb_array_update_pipe;
  import array_update_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  sel;
  logic [FLAT_W-1:0] arr;
  logic [ELEM_W-1:0] value;
  logic              out_valid;
  logic              out_ready;
  logic [FLAT_W-1:0] out;
`ifdef ARRAY_UPDATE_OOB_FLAG_EN
  logic              oob;
`endif

  array_update_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .arr       (arr),
    .value     (value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef ARRAY_UPDATE_OOB_FLAG_EN
    , .oob     (oob)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FLAT_W-1:0] data;
    bit                oob;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   accepts    = 0;
  int   fire_cnt   = 0;
  int   fire_first = 0;
  int   fire_last  = 0;
  bit   stall_prev = 0;
  logic [FLAT_W-1:0] prev_out;

  localparam logic [FLAT_W-1:0] BASIC_ARR = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [FLAT_W-1:0] BASIC_EXP = {32'd4, 32'd3, 32'h0000_00AA, 32'd1};

  // Reference: write index is sel+1 computed as an integer; indices past the end write nothing.
  function automatic exp_t model(input int s, input logic [FLAT_W-1:0] a, input logic [ELEM_W-1:0] v);
    exp_t e;
    int   idx;
    idx    = s + 1;
    e.data = a;
    e.oob  = (idx >= NUM_ELEMS);
    if (idx < NUM_ELEMS) e.data[idx*ELEM_W +: ELEM_W] = v;
    return e;
  endfunction

  task automatic check(input string tag, input logic [FLAT_W-1:0] obs, input logic [FLAT_W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [FLAT_W-1:0] rand_arr();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called just after the inputs are driven at a negedge; returns at the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (stall_prev) begin
      check("hold_valid", FLAT_W'(out_valid), FLAT_W'(1));
      check("hold_data", out, prev_out);
    end
    if (out_valid && out_ready) begin
      check("out_expected", FLAT_W'(q.size() != 0), FLAT_W'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        check("out_data", out, e.data);
`ifdef ARRAY_UPDATE_OOB_FLAG_EN
        check("out_oob", FLAT_W'(oob), FLAT_W'(e.oob));
`endif
      end
      fire_cnt++;
      if (fire_cnt == 1) fire_first = cyc;
      fire_last = cyc;
    end
    if (in_valid && in_ready) begin
      q.push_back(model(int'(sel), arr, value));
      accepts++;
    end
    stall_prev = out_valid && !out_ready;
    prev_out   = out;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input int s, input logic [FLAT_W-1:0] a,
                       input logic [ELEM_W-1:0] val, input bit ordy);
    in_valid  = v;
    sel       = SEL_W'(s);
    arr       = a;
    value     = val;
    out_ready = ordy;
    tick();
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(1'b0, 0, '0, '0, ordy);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = '0; arr = '0; value = '0;
    prev_out = '0;

    // Reset state and release.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_out_valid", FLAT_W'(out_valid), FLAT_W'(0));
    check("rst_out", out, '0);
    check("rst_in_ready", FLAT_W'(in_ready), FLAT_W'(0));
    rst_n = 1'b1;
    #1 check("release_in_ready_pre_edge", FLAT_W'(in_ready), FLAT_W'(0));
    @(negedge clk); #1;
    check("release_in_ready", FLAT_W'(in_ready), FLAT_W'(1));

    // Basic update with 2-cycle latency.
    drive(1'b1, 0, BASIC_ARR, 32'h0000_00AA, 1'b1);
    #1 check("basic_lat1_valid", FLAT_W'(out_valid), FLAT_W'(0));
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("basic_lat2_valid", FLAT_W'(out_valid), FLAT_W'(1));
    check("basic_data", out, BASIC_EXP);
`ifdef ARRAY_UPDATE_OOB_FLAG_EN
    check("basic_oob", FLAT_W'(oob), FLAT_W'(0));
`endif
    idle(1, 1'b1);
    check("basic_drained", FLAT_W'(q.size()), '0);

    // Out-of-bounds select: array passes unchanged, element 0 not touched.
    arr = rand_arr();
    drive(1'b1, 3, arr, 32'h0000_00FF, 1'b1);
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("oob_data_unchanged", out, arr);
`ifdef ARRAY_UPDATE_OOB_FLAG_EN
    check("oob_flag", FLAT_W'(oob), FLAT_W'(1));
`endif
    idle(2, 1'b1);

    // Throughput: 8 back-to-back transactions give 8 consecutive outputs.
    fire_cnt = 0;
    for (int i = 0; i < 8; i++) drive(1'b1, i % 3, rand_arr(), $urandom, 1'b1);
    idle(3, 1'b1);
    check("tput_count", FLAT_W'(fire_cnt), FLAT_W'(8));
    check("tput_consecutive", FLAT_W'(fire_last - fire_first), FLAT_W'(7));

    // Backpressure: 5 stalled cycles accept exactly 2, then drain with random readiness.
    accepts = 0;
    for (int i = 0; i < 5; i++) drive(1'b1, $urandom_range(0, 3), rand_arr(), $urandom, 1'b0);
    check("bp_accepts", FLAT_W'(accepts), FLAT_W'(2));
    #1 check("bp_in_ready_low", FLAT_W'(in_ready), FLAT_W'(0));
    for (int i = 0; i < 40; i++)
      drive($urandom_range(0, 1), $urandom_range(0, 3), rand_arr(), $urandom, $urandom_range(0, 3) != 0);
    idle(4, 1'b1);
    check("bp_drained", FLAT_W'(q.size()), '0);

    // Mid-operation reset with both stages full.
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom_range(0, 3), rand_arr(), $urandom, 1'b0);
    #1;
    check("full_out_valid", FLAT_W'(out_valid), FLAT_W'(1));
    check("full_in_ready", FLAT_W'(in_ready), FLAT_W'(0));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", FLAT_W'(out_valid), FLAT_W'(0));
    check("midrst_out", out, '0);
    check("midrst_in_ready", FLAT_W'(in_ready), FLAT_W'(0));
    q.delete();
    stall_prev = 0;
    in_valid   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fire_cnt = 0;
    idle(5, 1'b1);
    check("midrst_no_stale", FLAT_W'(fire_cnt), '0);

    // Short random soak after reset.
    for (int i = 0; i < 60; i++)
      drive($urandom_range(0, 1), $urandom_range(0, 3), rand_arr(), $urandom, $urandom_range(0, 1));
    idle(4, 1'b1);
    check("final_drained", FLAT_W'(q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
